// File: rtl/lcd_init_seq.sv
// Panel init sequencer: after power-ready, walks a small command ROM and emits
// command/data bytes over a valid/ready handshake, with embedded ms delays.
module lcd_init_seq #(
   parameter int CLK_FREQ  = 12000000,
   parameter int ROM_DEPTH = 32
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       pwr_ready,
   output logic [7:0] tx_data,
   output logic       tx_dc,
   output logic       tx_valid,
   input  logic       tx_ready,
   output logic       busy,
   output logic       init_done
);

   localparam int T  = CLK_FREQ / 1000;
   localparam int AW = (ROM_DEPTH > 1) ? $clog2(ROM_DEPTH) : 1;
   localparam int TW = (T > 1) ? $clog2(T) : 1;

   localparam logic [TW-1:0] T_LAST   = TW'(T - 1);
   localparam logic [AW-1:0] LAST_IDX = AW'(ROM_DEPTH - 1);

   typedef enum logic [1:0] {
      TY_CMD   = 2'b00,
      TY_DATA  = 2'b01,
      TY_DELAY = 2'b10,
      TY_END   = 2'b11
   } entry_t;

   typedef enum logic [2:0] {
      S_IDLE,
      S_FETCH,
      S_SEND,
      S_DELAY,
      S_DONE
   } state_t;

   state_t        state, state_next;
   logic [AW-1:0] index, index_next;
   logic [7:0]    data_next;
   logic          dc_next;
   logic          valid_next;
   logic [TW-1:0] tick_cnt, tick_next;
   logic [8:0]    ms_left, ms_next;

   logic [9:0]    rom_word;
   entry_t        rom_type;
   logic [7:0]    rom_value;

   // Command ROM; the last addressable entry always reads as END so the index
   // can never run past the table.
   always_comb begin
      rom_word = {2'b11, 8'h00};
      case (int'(index))
         0:       rom_word = {2'b00, 8'h01};
         1:       rom_word = {2'b10, 8'd150};
         2:       rom_word = {2'b00, 8'h11};
         3:       rom_word = {2'b10, 8'd120};
         4:       rom_word = {2'b00, 8'h3A};
         5:       rom_word = {2'b01, 8'h55};
         6:       rom_word = {2'b00, 8'h29};
         default: rom_word = {2'b11, 8'h00};
      endcase
      if (index == LAST_IDX) begin
         rom_word = {2'b11, 8'h00};
      end
   end

   assign rom_type  = entry_t'(rom_word[9:8]);
   assign rom_value = rom_word[7:0];

   always_ff @(posedge clk) begin
      if (reset) begin
         state    <= S_IDLE;
         index    <= '0;
         tx_data  <= '0;
         tx_dc    <= 1'b0;
         tx_valid <= 1'b0;
         tick_cnt <= '0;
         ms_left  <= '0;
      end else begin
         state    <= state_next;
         index    <= index_next;
         tx_data  <= data_next;
         tx_dc    <= dc_next;
         tx_valid <= valid_next;
         tick_cnt <= tick_next;
         ms_left  <= ms_next;
      end
   end

   always_comb begin
      state_next = state;
      index_next = index;
      data_next  = tx_data;
      dc_next    = tx_dc;
      valid_next = tx_valid;
      tick_next  = tick_cnt;
      ms_next    = ms_left;

      case (state)
         S_IDLE: begin
            index_next = '0;
            valid_next = 1'b0;
            if (pwr_ready) begin
               state_next = S_FETCH;
            end
         end

         S_FETCH: begin
            case (rom_type)
               TY_CMD, TY_DATA: begin
                  state_next = S_SEND;
                  data_next  = rom_value;
                  dc_next    = (rom_type == TY_DATA);
                  valid_next = 1'b1;
               end
               TY_DELAY: begin
                  state_next = S_DELAY;
                  tick_next  = '0;
                  ms_next    = (rom_value == 8'd0) ? 9'd256 : {1'b0, rom_value};
               end
               TY_END: begin
                  state_next = S_DONE;
               end
            endcase
         end

         S_SEND: begin
            if (tx_ready) begin
               valid_next = 1'b0;
               index_next = index + AW'(1);
               state_next = S_FETCH;
            end
         end

         // One ms per tick_cnt wrap; leaves on the wrap that consumes the last ms.
         S_DELAY: begin
            if (tick_cnt == T_LAST) begin
               tick_next = '0;
               if (ms_left == 9'd1) begin
                  index_next = index + AW'(1);
                  state_next = S_FETCH;
               end else begin
                  ms_next = ms_left - 9'd1;
               end
            end else begin
               tick_next = tick_cnt + TW'(1);
            end
         end

         S_DONE: begin
         end

         default: begin
            state_next = S_IDLE;
         end
      endcase

      // Power loss aborts from anywhere, even mid-handshake.
      if (state != S_IDLE && !pwr_ready) begin
         state_next = S_IDLE;
         index_next = '0;
         data_next  = '0;
         dc_next    = 1'b0;
         valid_next = 1'b0;
      end
   end

   assign busy      = (state == S_FETCH) || (state == S_SEND) || (state == S_DELAY);
   assign init_done = (state == S_DONE);

endmodule

// File: tb/tb_lcd_init_seq.sv
// Directed bench for lcd_init_seq at CLK_FREQ=120000 (T=120 cycles per ms).
module tb_lcd_init_seq;

   localparam int CLK_FREQ = 120000;

   logic       clk = 1'b0;
   logic       reset;
   logic       pwr_ready;
   logic       tx_ready;
   logic [7:0] tx_data;
   logic       tx_dc;
   logic       tx_valid;
   logic       busy;
   logic       init_done;

   logic [7:0] w_data;
   logic       w_dc;
   logic       w_valid;
   logic       w_busy;
   logic       w_done;

   int n_cmp = 0;
   int n_err = 0;
   int cyc   = 0;

   always #5 clk = ~clk;

   lcd_init_seq #(.CLK_FREQ(CLK_FREQ), .ROM_DEPTH(32)) dut (
      .clk       (clk),
      .reset     (reset),
      .pwr_ready (pwr_ready),
      .tx_data   (tx_data),
      .tx_dc     (tx_dc),
      .tx_valid  (tx_valid),
      .tx_ready  (tx_ready),
      .busy      (busy),
      .init_done (init_done)
   );

   // Three-entry ROM: entry 2 (a CMD in the table) must read as END.
   lcd_init_seq #(.CLK_FREQ(CLK_FREQ), .ROM_DEPTH(3)) dut_wrap (
      .clk       (clk),
      .reset     (reset),
      .pwr_ready (pwr_ready),
      .tx_data   (w_data),
      .tx_dc     (w_dc),
      .tx_valid  (w_valid),
      .tx_ready  (1'b1),
      .busy      (w_busy),
      .init_done (w_done)
   );

   task automatic tick();
      @(posedge clk);
      #1;
      cyc++;
   endtask

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   // Waits for tx_valid, checks the byte, then lets it handshake (tx_ready=1).
   task automatic expect_byte(input string tag, input logic [7:0] d, input logic dc,
                              input int budget, output int rise, output int hs);
      int n;
      n = 0;
      while (tx_valid !== 1'b1 && n < budget) begin
         tick();
         n++;
      end
      check({tag, " valid"}, {31'd0, tx_valid}, 32'd1);
      rise = cyc;
      check({tag, " data"}, {24'd0, tx_data}, {24'd0, d});
      check({tag, " dc"}, {31'd0, tx_dc}, {31'd0, dc});
      tick();
      hs = cyc;
   endtask

   initial begin
      int seen;
      int k;
      int r;
      int hs01, hs11, hs3a, hs55, hs29;
      int n;

      reset     = 1'b1;
      pwr_ready = 1'b0;
      tx_ready  = 1'b0;
      repeat (4) tick();
      check("rst data", {24'd0, tx_data}, 32'd0);
      check("rst dc", {31'd0, tx_dc}, 32'd0);
      check("rst valid", {31'd0, tx_valid}, 32'd0);
      check("rst busy", {31'd0, busy}, 32'd0);
      check("rst done", {31'd0, init_done}, 32'd0);

      reset = 1'b0;
      seen  = 0;
      repeat (1000) begin
         tick();
         if (tx_valid !== 1'b0 || busy !== 1'b0 || init_done !== 1'b0) seen++;
      end
      check("idle quiet", seen, 32'd0);

      // Full sequence, 0x3A held off by backpressure.
      tx_ready  = 1'b1;
      pwr_ready = 1'b1;
      tick();
      k = cyc;
      check("k valid low", {31'd0, tx_valid}, 32'd0);
      check("k busy", {31'd0, busy}, 32'd1);
      expect_byte("a01", 8'h01, 1'b0, 5, r, hs01);
      check("a01 latency", r - k, 32'd1);
      expect_byte("a11", 8'h11, 1'b0, 20000, r, hs11);
      check("a delay150", r - hs01, 32'd18002);
      check("wrap done", {31'd0, w_done}, 32'd1);
      check("wrap quiet", {31'd0, w_valid}, 32'd0);
      check("wrap busy", {31'd0, w_busy}, 32'd0);

      tx_ready = 1'b0;
      n = 0;
      while (tx_valid !== 1'b1 && n < 20000) begin
         tick();
         n++;
      end
      check("a3A delay120", cyc - hs11, 32'd14402);
      seen = 0;
      repeat (50) begin
         if (tx_valid !== 1'b1 || tx_data !== 8'h3A || tx_dc !== 1'b0) seen++;
         tick();
      end
      if (tx_valid !== 1'b1 || tx_data !== 8'h3A || tx_dc !== 1'b0) seen++;
      check("a3A hold", seen, 32'd0);
      tx_ready = 1'b1;
      tick();
      hs3a = cyc;
      expect_byte("a55", 8'h55, 1'b1, 5, r, hs55);
      check("a55 latency", r - hs3a, 32'd1);
      expect_byte("a29", 8'h29, 1'b0, 5, r, hs29);
      check("a b2b", hs29 - hs55, 32'd2);
      check("a fetch done", {31'd0, init_done}, 32'd0);
      check("a fetch busy", {31'd0, busy}, 32'd1);
      tick();
      check("a done", {31'd0, init_done}, 32'd1);
      check("a done busy", {31'd0, busy}, 32'd0);
      check("a done valid", {31'd0, tx_valid}, 32'd0);

      // Post-done hold, then a one-cycle power drop restarts the table.
      seen = 0;
      repeat (10000) begin
         tick();
         if (tx_valid !== 1'b0) seen++;
      end
      check("post quiet", seen, 32'd0);
      check("post done", {31'd0, init_done}, 32'd1);
      pwr_ready = 1'b0;
      tick();
      check("drop done", {31'd0, init_done}, 32'd0);
      check("drop busy", {31'd0, busy}, 32'd0);
      pwr_ready = 1'b1;
      tick();
      k = cyc;
      expect_byte("p01", 8'h01, 1'b0, 5, r, hs01);
      check("p01 latency", r - k, 32'd1);

      // Power loss 5000 cycles into the 150 ms delay.
      repeat (5001) tick();
      check("pl busy", {31'd0, busy}, 32'd1);
      check("pl valid", {31'd0, tx_valid}, 32'd0);
      pwr_ready = 1'b0;
      tick();
      check("pl busy off", {31'd0, busy}, 32'd0);
      check("pl valid off", {31'd0, tx_valid}, 32'd0);
      pwr_ready = 1'b1;
      tick();
      k = cyc;
      expect_byte("b01", 8'h01, 1'b0, 5, r, hs01);
      check("b01 latency", r - k, 32'd1);

      // 0x11 held by backpressure, then reset lands during SEND.
      tx_ready = 1'b0;
      n = 0;
      while (tx_valid !== 1'b1 && n < 20000) begin
         tick();
         n++;
      end
      check("b delay150", cyc - hs01, 32'd18002);
      check("b11 data", {24'd0, tx_data}, 32'h11);
      repeat (3) tick();
      check("b11 held", {31'd0, tx_valid}, 32'd1);
      reset = 1'b1;
      tick();
      check("rs valid", {31'd0, tx_valid}, 32'd0);
      check("rs data", {24'd0, tx_data}, 32'd0);
      check("rs dc", {31'd0, tx_dc}, 32'd0);
      check("rs busy", {31'd0, busy}, 32'd0);
      check("rs done", {31'd0, init_done}, 32'd0);
      reset = 1'b0;
      tick();
      k = cyc;
      tx_ready = 1'b1;
      expect_byte("c01", 8'h01, 1'b0, 5, r, hs01);
      check("c01 latency", r - k, 32'd1);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
